// File: rtl/turbo_decoder_hd_if.sv
// Stream and status bundle between the hard-decision turbo decoder and its wrapper.
// The slave side is the decoder; the master side is the symbol source / bit sink.
interface turbo_decoder_hd_if #(
  parameter int CNT_W = 13
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_sym;
  logic             out_valid;
  logic             out_ready;
  logic             out_bit;
  logic             out_last;
  logic             frame_done;
  logic [CNT_W-1:0] par_err_cnt;
  logic             term_err;
  logic             busy;

  modport master (
    output in_valid, in_sym, out_ready,
    input  in_ready, out_valid, out_bit, out_last,
    input  frame_done, par_err_cnt, term_err, busy
  );

  modport slave (
    input  in_valid, in_sym, out_ready,
    output in_ready, out_valid, out_bit, out_last,
    output frame_done, par_err_cnt, term_err, busy
  );
endinterface

// File: rtl/turbo_decoder_hd.sv
// Hard-decision turbo receive path: re-encodes constituent encoder 1 to count parity1
// errors and check its trellis termination, and streams out the systematic bits.
//
// state | meaning
// IDLE  | waiting for data symbol 0 of a new frame
// DATA  | data symbols 1..K-1, systematic bit forwarded to the output register
// TAIL1 | three encoder-1 termination symbols, checked against the RSC state
// TAIL2 | three encoder-2 termination symbols, consumed and ignored
// DONE  | one-cycle frame_done pulse, no input accepted
module turbo_decoder_hd #(
  parameter int K     = 40,
  parameter int CNT_W = 13
) (
  input logic              wb_clk_i,
  input logic              wb_rst_i,
  turbo_decoder_hd_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DATA  = 3'd1,
    TAIL1 = 3'd2,
    TAIL2 = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       rsc_q, rsc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] par_q, par_d;
  logic             term_q, term_d;
  logic             ov_q, ov_d;
  logic             ob_q, ob_d;
  logic             ol_q, ol_d;

  logic in_ready;
  logic acc;
  logic load;
  logic load_last;

  logic s1, s2, s3;
  logic x, z;
  logic a_data, z_data;
  logic x_tail, z_tail;
  logic unused_parity2;

  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] LAST_TAIL = CNT_W'(2);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign s1 = rsc_q[2];
  assign s2 = rsc_q[1];
  assign s3 = rsc_q[0];
  assign x  = bus.in_sym[2];
  assign z  = bus.in_sym[1];
  assign unused_parity2 = bus.in_sym[0];

  // Data steps feed x into the recursion; tail steps force the feedback bit to zero.
  assign a_data = x ^ s2 ^ s3;
  assign z_data = a_data ^ s1 ^ s3;
  assign x_tail = s2 ^ s3;
  assign z_tail = s1 ^ s3;

  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      IDLE:    in_ready = 1'b1;
      DATA:    in_ready = !ov_q || bus.out_ready;
      TAIL1:   in_ready = 1'b1;
      TAIL2:   in_ready = 1'b1;
      DONE:    in_ready = 1'b0;
      default: in_ready = 1'b0;
    endcase
  end

  assign acc = bus.in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    rsc_d     = rsc_q;
    cnt_d     = cnt_q;
    par_d     = par_q;
    term_d    = term_q;
    load      = 1'b0;
    load_last = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (acc) begin
          par_d     = (z != z_data) ? CNT_W'(1) : '0;
          term_d    = 1'b0;
          rsc_d     = {a_data, s1, s2};
          load      = 1'b1;
          load_last = (K == 1);
          cnt_d     = CNT_W'(1);
          state_d   = DATA;
        end
      end
      DATA: begin
        if (acc) begin
          rsc_d     = {a_data, s1, s2};
          load      = 1'b1;
          load_last = (cnt_q == LAST_DATA);
          if (z != z_data) par_d = sat_inc(par_q);
          if (cnt_q == LAST_DATA) begin
            cnt_d   = '0;
            state_d = TAIL1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      TAIL1: begin
        if (acc) begin
          rsc_d = {1'b0, s1, s2};
          if (x != x_tail) term_d = 1'b1;
          if (z != z_tail) par_d = sat_inc(par_q);
          if (cnt_q == LAST_TAIL) begin
            // Termination must leave the encoder in the all-zero state.
            if ({1'b0, s1, s2} != 3'b000) term_d = 1'b1;
            cnt_d   = '0;
            state_d = TAIL2;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      TAIL2: begin
        if (acc) begin
          if (cnt_q == LAST_TAIL) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ov_d = ov_q;
    ob_d = ob_q;
    ol_d = ol_q;
    if (load) begin
      ov_d = 1'b1;
      ob_d = x;
      ol_d = load_last;
    end else if (bus.out_ready) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      rsc_q   <= 3'b000;
      cnt_q   <= '0;
      par_q   <= '0;
      term_q  <= 1'b0;
      ov_q    <= 1'b0;
      ob_q    <= 1'b0;
      ol_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rsc_q   <= rsc_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      term_q  <= term_d;
      ov_q    <= ov_d;
      ob_q    <= ob_d;
      ol_q    <= ol_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = ov_q;
  assign bus.out_bit     = ob_q;
  assign bus.out_last    = ol_q;
  assign bus.frame_done  = (state_q == DONE);
  assign bus.par_err_cnt = par_q;
  assign bus.term_err    = term_q;
  assign bus.busy        = (state_q != IDLE);

endmodule
